// File: rtl/vdp_super_pkg.sv
// Shared definitions for the super-res/super-mid framebuffer write path.
package vdp_super_pkg;

    localparam int ADDR_W   = 19;
    localparam int DWORD_AW = 17;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/vdp_super_res_wr_fifo.sv
// Synchronous byte-write queue; a push into a full queue is honoured when a pop happens the same cycle.
module vdp_super_res_wr_fifo
    import vdp_super_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = IW + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    wr_entry_t     mem_q [DEPTH];
    logic [IW-1:0] wr_q;
    logic [IW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Accepted push/pop and next occupancy
    always_comb begin
        pop_ok_s  = pop_i && (count_q != '0);
        push_ok_s = push_i && (!full_q || pop_ok_s);
        count_d   = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointers, occupancy and the registered full flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (clear_i) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push_ok_s) wr_q <= wr_q + IW'(1);
                if (pop_ok_s)  rd_q <= rd_q + IW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage array
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !clear_i) mem_q[wr_q] <= wr_entry_t'(push_data_i);
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/vdp_super_res_writer.sv
// CPU byte-stream writer into the super-res framebuffer: auto-incrementing pointer,
// byte queue, and a drain FSM that issues byte-masked dword writes outside the display window.
module vdp_super_res_writer
    import vdp_super_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                vdp_super_i,
    input  logic                super_res_drawing_i,
    input  logic                addr_load_i,
    input  logic [ADDR_W-1:0]   addr_in_i,
    input  logic                cpu_wr_i,
    input  logic [7:0]          cpu_data_i,
    output logic                fifo_full_o,
    output logic                overflow_o,
    output logic                busy_o,
    output logic                vram_wr_req_o,
    output logic [DWORD_AW-1:0] vram_wr_addr_o,
    output logic [31:0]         vram_wr_data_o,
    output logic [3:0]          vram_wr_be_o,
    input  logic                vram_wr_ack_i
);

    drain_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ovf_q, ovf_d;
    logic                req_q, req_d;
    logic [DWORD_AW-1:0] addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          be_q, be_d;

    logic [ADDR_W-1:0]   base_s;
    logic                wr_en_s, push_s, pop_s, drop_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [CW-1:0]       fifo_count_s;
    logic [ENTRY_W-1:0]  head_raw_s;
    wr_entry_t           head_s, push_entry_s;

    vdp_super_res_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (state_q == ST_FLUSH),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_raw_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Pointer, enqueue and overflow; a same-cycle load redirects the byte to addr_in
    always_comb begin
        head_s       = wr_entry_t'(head_raw_s);
        base_s       = addr_load_i ? addr_in_i : ptr_q;
        wr_en_s      = cpu_wr_i && vdp_super_i && (state_q != ST_FLUSH);
        pop_s        = (state_q == ST_IDLE) && !fifo_empty_s && !super_res_drawing_i && vdp_super_i;
        push_s       = wr_en_s && (!fifo_full_s || pop_s);
        drop_s       = wr_en_s && fifo_full_s && !pop_s;
        push_entry_s = '{addr: base_s, data: cpu_data_i};
        ptr_d        = wr_en_s ? (base_s + ADDR_W'(1)) : base_s;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (addr_load_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Drain FSM; a request, once raised, is held until acked regardless of drawing/vdp_super
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    addr_d  = head_s.addr[ADDR_W-1:2];
                    be_d    = lane_be(head_s.addr[1:0]);
                    data_d  = {4{head_s.data}};
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (!vdp_super_i) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (vram_wr_ack_i) begin
                    req_d   = 1'b0;
                    state_d = vdp_super_i ? ST_IDLE : ST_FLUSH;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                state_d = vdp_super_i ? ST_IDLE : ST_FLUSH;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'h0000_0000;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

    assign fifo_full_o    = fifo_full_s;
    assign overflow_o     = ovf_q;
    assign busy_o         = (fifo_count_s != '0) || (state_q != ST_IDLE);
    assign vram_wr_req_o  = req_q;
    assign vram_wr_addr_o = addr_q;
    assign vram_wr_data_o = data_q;
    assign vram_wr_be_o   = be_q;

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Scoreboard bench for vdp_super_res_writer: expected writes are queued as bytes are driven
// and retired by the acking responder when the DUT presents its request.
module tb_vdp_super_res_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        vdp_super;
    logic        drawing;
    logic        addr_load;
    logic [18:0] addr_in;
    logic        cpu_wr;
    logic [7:0]  cpu_data;
    logic        fifo_full;
    logic        overflow;
    logic        busy;
    logic        vram_wr_req;
    logic [16:0] vram_wr_addr;
    logic [31:0] vram_wr_data;
    logic [3:0]  vram_wr_be;
    logic        vram_wr_ack;

    typedef struct {
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [18:0] tb_ptr;
    bit          ack_en    = 1'b1;
    int          ack_delay = 0;

    always #5 clk = ~clk;

    vdp_super_res_writer #(.FIFO_DEPTH(4)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .vdp_super_i         (vdp_super),
        .super_res_drawing_i (drawing),
        .addr_load_i         (addr_load),
        .addr_in_i           (addr_in),
        .cpu_wr_i            (cpu_wr),
        .cpu_data_i          (cpu_data),
        .fifo_full_o         (fifo_full),
        .overflow_o          (overflow),
        .busy_o              (busy),
        .vram_wr_req_o       (vram_wr_req),
        .vram_wr_addr_o      (vram_wr_addr),
        .vram_wr_data_o      (vram_wr_data),
        .vram_wr_be_o        (vram_wr_be),
        .vram_wr_ack_i       (vram_wr_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [18:0] a);
        addr_load = 1'b1;
        addr_in   = a;
        tb_ptr    = a;
        @(negedge clk);
        addr_load = 1'b0;
    endtask

    // mode 0: accepted and expected on the bus; 1: pointer advances but no bus write; 2: ignored
    task automatic wr(input logic [7:0] d, input int mode);
        exp_t e;
        cpu_wr   = 1'b1;
        cpu_data = d;
        if (mode == 0) begin
            e.addr = tb_ptr[18:2];
            e.be   = 4'b0001 << tb_ptr[1:0];
            e.data = {4{d}};
            sb.push_back(e);
        end
        if (mode <= 1) tb_ptr = tb_ptr + 19'd1;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (busy || sb.size() != 0); i++) @(negedge clk);
        check_eq("drain_busy", busy, 1'b0);
        check_eq("drain_sb_left", sb.size(), 0);
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget && !vram_wr_req; i++) @(negedge clk);
        check_eq("req_timeout", vram_wr_req, 1'b1);
    endtask

    // Arbiter model: retires the scoreboard head against the presented request
    initial begin
        exp_t e;
        vram_wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && vram_wr_req && !reset) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_req", vram_wr_req, 1'b0);
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k <= ack_delay; k++) begin
                        check_eq("req_held", vram_wr_req, 1'b1);
                        check_eq("wr_addr", vram_wr_addr, e.addr);
                        check_eq("wr_be", vram_wr_be, e.be);
                        check_eq("wr_data", vram_wr_data, e.data);
                        if (k < ack_delay) @(negedge clk);
                    end
                end
                vram_wr_ack = 1'b1;
                @(negedge clk);
                vram_wr_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        vdp_super = 1'b1;
        drawing   = 1'b0;
        addr_load = 1'b0;
        addr_in   = 19'd0;
        cpu_wr    = 1'b0;
        cpu_data  = 8'd0;
        tb_ptr    = 19'd0;
        tick(3);
        reset = 1'b0;
        tick(1);

        check_eq("rst_full", fifo_full, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req", vram_wr_req, 1'b0);
        check_eq("rst_addr", vram_wr_addr, 17'd0);
        check_eq("rst_data", vram_wr_data, 32'd0);
        check_eq("rst_be", vram_wr_be, 4'd0);

        // Basic write with latency
        load(19'h00005);
        wr(8'hA7, 0);
        check_eq("lat_n1_req", vram_wr_req, 1'b0);
        tick(1);
        check_eq("lat_n2_req", vram_wr_req, 1'b1);
        wait_idle(50);

        // Drawing gate
        drawing = 1'b1;
        load(19'h00010);
        wr(8'h11, 0);
        wr(8'h22, 0);
        wr(8'h33, 0);
        for (int i = 0; i < 5; i++) begin
            check_eq("gate_no_req", vram_wr_req, 1'b0);
            tick(1);
        end
        drawing = 1'b0;
        wait_idle(100);

        // Full and overflow
        drawing = 1'b1;
        load(19'h00020);
        wr(8'h40, 0);
        wr(8'h41, 0);
        wr(8'h42, 0);
        check_eq("full_at3", fifo_full, 1'b0);
        wr(8'h43, 0);
        check_eq("full_at4", fifo_full, 1'b1);
        check_eq("ovf_at4", overflow, 1'b0);
        wr(8'h44, 1);
        check_eq("ovf_drop", overflow, 1'b1);
        check_eq("full_drop", fifo_full, 1'b1);
        drawing = 1'b0;
        wait_idle(100);
        wr(8'h45, 0);
        wait_idle(50);
        check_eq("ovf_sticky", overflow, 1'b1);
        load(19'h00100);
        check_eq("ovf_cleared", overflow, 1'b0);

        // Pointer wrap
        load(19'h7FFFF);
        wr(8'h5A, 0);
        wr(8'hC3, 0);
        wait_idle(50);

        // Held request under drawing and slow ack
        ack_delay = 10;
        load(19'h00203);
        wr(8'h9E, 0);
        wait_req(10);
        drawing = 1'b1;
        wait_idle(50);
        drawing   = 1'b0;
        ack_delay = 0;

        // vdp_super drop with an outstanding request
        ack_en = 1'b0;
        load(19'h00300);
        wr(8'h71, 0);
        wait_req(10);
        wr(8'h72, 1);
        wr(8'h73, 1);
        wr(8'h74, 1);
        vdp_super = 1'b0;
        tick(3);
        check_eq("flush_req_kept", vram_wr_req, 1'b1);
        ack_en = 1'b1;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            check_eq("flush_no_req", vram_wr_req, 1'b0);
            tick(1);
        end
        check_eq("flush_busy", busy, 1'b1);
        wr(8'h75, 2);
        tick(2);
        check_eq("flush_full", fifo_full, 1'b0);
        vdp_super = 1'b1;
        tick(2);
        check_eq("unflush_busy", busy, 1'b0);
        wr(8'h76, 0);
        wait_idle(50);

        // Reset during a request
        ack_en = 1'b0;
        wr(8'h88, 0);
        wait_req(10);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_req", vram_wr_req, 1'b0);
        check_eq("rst_mid_busy", busy, 1'b0);
        sb.delete();
        tick(2);
        reset  = 1'b0;
        tb_ptr = 19'd0;
        tick(1);
        ack_en = 1'b1;
        check_eq("rst_mid_addr", vram_wr_addr, 17'd0);
        check_eq("rst_mid_be", vram_wr_be, 4'd0);
        wr(8'h99, 0);
        wait_idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_super_res_writer.md
Name: vdp_super_res_writer

Overview:
CPU-side write path into the super-res/super-mid framebuffer in SDRAM. It is the write counterpart of the super-res display reader, which fetches 32-bit words at 17-bit dword addresses.
- The CPU loads a byte pointer, then streams bytes with auto-increment.
- Bytes are queued in a small FIFO.
- Bytes are drained as byte-masked 32-bit writes, and only while the display reader is outside its bus-arbitration window (super_res_drawing low).
- Sits between the VDP port decoder and the VRAM address/data mux.

Parameters:
FIFO_DEPTH, 4, entries in the byte queue (power of two, 2..16)
ADDR_W, 19, byte-address width (17-bit dword address plus 2-bit byte lane)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vdp_super  in  1  super modes enabled; low = writer disabled/flushed
super_res_drawing  in  1  display reader owns the bus; no new request may start
addr_load  in  1  one-cycle strobe: load byte pointer from addr_in
addr_in  in  19  new byte pointer
cpu_wr  in  1  one-cycle strobe: enqueue cpu_data at the pointer
cpu_data  in  8  byte to write
fifo_full  out  1  queue full; a further cpu_wr is dropped
overflow  out  1  sticky; set by a dropped write, cleared by addr_load
busy  out  1  queue non-empty or request outstanding
vram_wr_req  out  1  write request to SDRAM arbiter
vram_wr_addr  out  17  dword address
vram_wr_data  out  32  byte replicated on all four lanes
vram_wr_be  out  4  one-hot lane enable
vram_wr_ack  in  1  one-cycle completion pulse from arbiter

Behaviour:
- Reset values: pointer=0, FIFO empty, fifo_full=0, overflow=0, busy=0, vram_wr_req=0, vram_wr_addr=0, vram_wr_data=0, vram_wr_be=0.
- Pointer:
  - addr_load sets ptr=addr_in.
  - An accepted cpu_wr enqueues {ptr,cpu_data} and sets ptr=ptr+1, modulo 2^19 (0x7FFFF wraps to 0).
  - addr_load and cpu_wr in the same cycle: the byte goes to addr_in, and ptr becomes addr_in+1.
- FIFO:
  - Enqueue and dequeue in the same cycle are both honoured, even when full.
  - cpu_wr while full with no dequeue that cycle: the byte is dropped, the pointer still increments, and overflow is set.
  - fifo_full is registered and exact (count==FIFO_DEPTH).
- Drain FSM, three states:
  - IDLE:
    - If FIFO non-empty && !super_res_drawing && vdp_super: pop the head; load vram_wr_addr=entry[18:2], vram_wr_be=1<<entry[1:0], vram_wr_data={4{byte}}; go to REQ.
  - REQ:
    - vram_wr_req=1, held stable with addr/data/be until vram_wr_ack.
    - super_res_drawing rising while in REQ does not withdraw the request.
    - On ack: vram_wr_req=0; go to IDLE.
  - FLUSH:
    - Entered from IDLE when vdp_super=0.
    - Clears the FIFO and ignores cpu_wr.
    - Returns to IDLE when vdp_super=1.
    - The pointer is preserved.
    - If vdp_super falls while in REQ, the request completes first, then the FSM goes to FLUSH.
- Timing and latency:
  - cpu_wr at cycle N, FIFO empty, drawing low: vram_wr_req is high from cycle N+2 (N+1: entry visible; N+1 edge: pop).
  - Back-to-back throughput: one write per ack plus one idle cycle.
- Ack handling: an ack outside REQ is ignored.
- busy = (count!=0) | (state!=IDLE).
- Reset mid-request drops the request immediately; no completion is owed.

Decomposition:
- Shared package (custom_timings or a new vdp_super_pkg) holds:
  - ADDR_W;
  - the dword-address width (17, shared with the display reader);
  - typedef wr_entry_t {logic [18:0] addr; logic [7:0] data};
  - the drain-state enum {IDLE, REQ, FLUSH}.
- One sub-module: vdp_super_res_wr_fifo, a synchronous FIFO of wr_entry_t with full/empty/count. The pointer logic and FSM stay in the top.

Test Plan:
- Basic write: addr_load 0x00005, cpu_wr 0xA7, drawing=0 -> req at +2 with addr=0x00001, be=4'b0010, data=0xA7A7A7A7; ack -> req drops, busy=0.
- Drawing gate: drawing=1, write 3 bytes from 0x00010 -> no req. Drawing falls -> three requests in order: addr 0x00004, be 0001/0010/0100.
- Full and overflow: FIFO_DEPTH=4, drawing=1, 5 cpu_wr -> fifo_full=1 after the 4th, 5th dropped, overflow=1, pointer=start+5. addr_load clears overflow.
- Wrap: addr_load 0x7FFFF, two writes -> first addr 0x1FFFF be 1000, second addr 0x00000 be 0001.
- Held request: req asserted, then drawing rises and ack is delayed 10 cycles -> req, addr, data and be stay stable until ack.
- vdp_super drop: 3 queued, request outstanding, vdp_super=0 -> outstanding request completes on ack, FIFO flushed, no further req, cpu_wr ignored. vdp_super=1 -> pointer unchanged; an async reset during REQ clears req the same cycle.
